// File: rtl/ap_fifo_frame_pkg.sv
// Shared framing definitions: FSM states, header field offsets and the default magic word.
package ap_fifo_frame_pkg;

  typedef enum logic [1:0] {
    HDR      = 2'd0,
    EMIT_HDR = 2'd1,
    PAYLOAD  = 2'd2
  } state_t;

  localparam int          LEN_LSB   = 0;
  localparam int          MAGIC_LSB = 32;
  localparam logic [31:0] DEF_MAGIC = 32'hC0DE_F00D;

endpackage

// File: rtl/ap_fifo_frame_gate.sv
// Header-validating frame gate in front of an IP ap_fifo input; payload is a zero-latency pass-through.
// Headers pop without downstream space; payload beats move only when both sides are ready, else stall.
module ap_fifo_frame_gate
  import ap_fifo_frame_pkg::*;
#(
  parameter int          DATA_W    = 128,
  parameter int          LEN_W     = 32,
  parameter logic [31:0] MAGIC     = DEF_MAGIC,
  parameter int          MAX_BEATS = 65536,
  parameter bit          FWD_HDR   = 1'b0
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [DATA_W-1:0] in_V_V_dout,
  input  logic              in_V_V_empty_n,
  output logic              in_V_V_read,
  output logic [DATA_W-1:0] out_V_V_din,
  input  logic              out_V_V_full_n,
  output logic              out_V_V_write,
  output logic [31:0]       frame_cnt,
  output logic [15:0]       err_cnt,
  output logic              busy
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BEATS);

  state_t              r_state;
  logic [LEN_W-1:0]    r_remaining;
  logic [DATA_W-1:0]   r_hdr;
  logic [31:0]         r_frame_cnt;
  logic [15:0]         r_err_cnt;
  logic                r_busy;

  logic [LEN_W-1:0]    w_hdr_len;
  logic                w_magic_ok;
  logic                w_len_zero;
  logic                w_len_ok;
  logic                w_xfer;

  assign w_hdr_len  = in_V_V_dout[LEN_LSB +: LEN_W];
  assign w_magic_ok = (in_V_V_dout[MAGIC_LSB +: 32] == MAGIC);
  assign w_len_zero = (w_hdr_len == '0);
  assign w_len_ok   = !w_len_zero && (w_hdr_len <= MAX_LEN);
  assign w_xfer     = in_V_V_empty_n & out_V_V_full_n;

  // Strobes are combinational so payload passes straight through; reset masks them.
  always_comb begin
    in_V_V_read   = 1'b0;
    out_V_V_write = 1'b0;
    out_V_V_din   = in_V_V_dout;
    if (!ap_rst) begin
      case (r_state)
        HDR:      in_V_V_read = in_V_V_empty_n;
        EMIT_HDR: begin
          out_V_V_write = out_V_V_full_n;
          out_V_V_din   = r_hdr;
        end
        PAYLOAD:  begin
          in_V_V_read   = w_xfer;
          out_V_V_write = w_xfer;
        end
        default:  in_V_V_read = 1'b0;
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state     <= HDR;
      r_remaining <= '0;
      r_hdr       <= '0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        HDR: begin
          if (in_V_V_empty_n) begin
            if (w_magic_ok && w_len_ok) begin
              r_remaining <= w_hdr_len;
              r_hdr       <= in_V_V_dout;
              r_state     <= FWD_HDR ? EMIT_HDR : PAYLOAD;
              r_busy      <= 1'b1;
            end else if (w_magic_ok && w_len_zero) begin
              r_frame_cnt <= r_frame_cnt + 32'd1;
            end else if (r_err_cnt != 16'hFFFF) begin
              // Junk is dropped one word at a time until a valid header lines up again.
              r_err_cnt <= r_err_cnt + 16'd1;
            end
          end
        end
        EMIT_HDR: begin
          if (out_V_V_full_n) r_state <= PAYLOAD;
        end
        PAYLOAD: begin
          if (w_xfer) begin
            r_remaining <= r_remaining - LEN_W'(1);
            if (r_remaining == LEN_W'(1)) begin
              r_frame_cnt <= r_frame_cnt + 32'd1;
              r_state     <= HDR;
              r_busy      <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= HDR;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
  assign busy      = r_busy;

endmodule

// File: tb/tb_ap_fifo_frame_gate.sv
// Bench for ap_fifo_frame_gate: two instances (header forwarding off/on) fed from word queues,
// checked every cycle against a stream-level framing model plus directed literal expectations.
module tb_ap_fifo_frame_gate;
  import ap_fifo_frame_pkg::*;

  localparam int          DW    = 128;
  localparam logic [31:0] MAGIC = DEF_MAGIC;
  localparam int          MAXB  = 65536;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic [DW-1:0] in_dout    [2];
  logic          in_empty_n [2];
  logic          in_read    [2];
  logic [DW-1:0] out_din    [2];
  logic          out_full_n [2];
  logic          out_write  [2];
  logic [31:0]   frame_cnt  [2];
  logic [15:0]   err_cnt    [2];
  logic          busy       [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model state per instance: words still owed to the current frame and counters.
  int            m_rem    [2];
  logic [31:0]   m_frames [2];
  int            m_errs   [2];
  logic [DW-1:0] up_q  [2][$];
  logic [DW-1:0] exp_q [2][$];
  logic [DW-1:0] out_log [2][$];
  int            out_cyc [2][$];

  bit rand_mode = 1'b0;
  int stall_at   [2];
  int stall_left [2];
  int wr_seen    [2];

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  ap_fifo_frame_gate #(.FWD_HDR(1'b0)) u_dut0 (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_V_V_dout(in_dout[0]), .in_V_V_empty_n(in_empty_n[0]), .in_V_V_read(in_read[0]),
    .out_V_V_din(out_din[0]), .out_V_V_full_n(out_full_n[0]), .out_V_V_write(out_write[0]),
    .frame_cnt(frame_cnt[0]), .err_cnt(err_cnt[0]), .busy(busy[0])
  );

  ap_fifo_frame_gate #(.FWD_HDR(1'b1)) u_dut1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_V_V_dout(in_dout[1]), .in_V_V_empty_n(in_empty_n[1]), .in_V_V_read(in_read[1]),
    .out_V_V_din(out_din[1]), .out_V_V_full_n(out_full_n[1]), .out_V_V_write(out_write[1]),
    .frame_cnt(frame_cnt[1]), .err_cnt(err_cnt[1]), .busy(busy[1])
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DW-1:0] mk_hdr(input logic [31:0] magic, input logic [31:0] len);
    return {$urandom, $urandom, magic, len};
  endfunction

  function automatic logic [DW-1:0] junk_word();
    return {$urandom, $urandom, 32'h1234_5678, $urandom};
  endfunction

  task automatic model_reset(input int k);
    m_rem[k]    = 0;
    m_frames[k] = '0;
    m_errs[k]   = 0;
    exp_q[k].delete();
  endtask

  // Framing rules applied to each word the DUT actually consumed.
  task automatic model_pop(input int k, input logic [DW-1:0] w);
    logic [31:0] mg;
    logic [31:0] ln;
    mg = w[63:32];
    ln = w[31:0];
    if (m_rem[k] > 0) begin
      exp_q[k].push_back(w);
      m_rem[k]--;
      if (m_rem[k] == 0) m_frames[k] = m_frames[k] + 32'd1;
    end else if (mg == MAGIC && ln != 0 && longint'(ln) <= longint'(MAXB)) begin
      m_rem[k] = int'(ln);
      if (k == 1) exp_q[k].push_back(w);
    end else if (mg == MAGIC && ln == 0) begin
      m_frames[k] = m_frames[k] + 32'd1;
    end else if (m_errs[k] < 65535) begin
      m_errs[k]++;
    end
  endtask

  task automatic run_port(input int k);
    logic          rd, wr, payload_phase, emit_phase;
    logic [DW-1:0] e;
    in_empty_n[k] = 1'b0;
    out_full_n[k] = 1'b1;
    in_dout[k]    = '0;
    stall_at[k]   = 0;
    stall_left[k] = 0;
    wr_seen[k]    = 0;
    forever begin
      @(negedge ap_clk);
      rd = in_read[k];
      wr = out_write[k];
      if (ap_rst) begin
        chk($sformatf("rst_read_dut%0d", k), rd, 1'b0);
        chk($sformatf("rst_write_dut%0d", k), wr, 1'b0);
        model_reset(k);
        rd = 1'b0;
      end else begin
        chk($sformatf("frame_cnt_dut%0d", k), frame_cnt[k], m_frames[k]);
        chk($sformatf("err_cnt_dut%0d", k), err_cnt[k], m_errs[k][15:0]);
        chk($sformatf("busy_dut%0d", k), busy[k], m_rem[k] > 0);
        payload_phase = (m_rem[k] > 0) && (exp_q[k].size() == 0);
        emit_phase    = (m_rem[k] > 0) && (exp_q[k].size() != 0);
        if (payload_phase) chk($sformatf("lockstep_dut%0d", k), rd, wr);
        if (emit_phase) chk($sformatf("read_in_emit_dut%0d", k), rd, 1'b0);
        if (rd) begin
          chk($sformatf("read_when_empty_dut%0d", k), in_empty_n[k], 1'b1);
          model_pop(k, in_dout[k]);
        end
        if (wr) begin
          chk($sformatf("write_when_full_dut%0d", k), out_full_n[k], 1'b1);
          tests++;
          if (exp_q[k].size() == 0) begin
            fails++;
            $display("FAIL spurious_write_dut%0d: got write of %h, required no write", k, out_din[k]);
          end else begin
            e = exp_q[k].pop_front();
            if (out_din[k] !== e) begin
              fails++;
              $display("FAIL out_data_dut%0d: got %h, required %h", k, out_din[k], e);
            end
          end
          out_log[k].push_back(out_din[k]);
          out_cyc[k].push_back(cyc);
          wr_seen[k]++;
          if (wr_seen[k] == stall_at[k]) stall_left[k] = 4;
        end
      end
      @(posedge ap_clk);
      #1;
      if (rd && up_q[k].size() != 0) void'(up_q[k].pop_front());
      if (stall_left[k] > 0) begin
        out_full_n[k] = 1'b0;
        stall_left[k]--;
      end else begin
        out_full_n[k] = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      in_empty_n[k] = (up_q[k].size() != 0) && (rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_dout[k]    = (up_q[k].size() != 0) ? up_q[k][0] : rnd_word();
    end
  endtask

  initial run_port(0);
  initial run_port(1);

  task automatic wait_idle(input int k, input int budget);
    int n;
    n = 0;
    while (!(up_q[k].size() == 0 && m_rem[k] == 0 && exp_q[k].size() == 0)) begin
      @(posedge ap_clk);
      n++;
      if (n > budget) begin
        tests++;
        fails++;
        $display("FAIL timeout_dut%0d: still busy after %0d cycles, required idle", k, budget);
        return;
      end
    end
    repeat (2) @(posedge ap_clk);
    #1;
  endtask

  task automatic check_log(input int k, input string nm, input logic [DW-1:0] e[$]);
    chk({nm, "_count"}, out_log[k].size(), e.size());
    for (int i = 0; i < e.size() && i < out_log[k].size(); i++)
      chk($sformatf("%s_word%0d", nm, i), out_log[k][i], e[i]);
  endtask

  task automatic clear_log(input int k);
    out_log[k].delete();
    out_cyc[k].delete();
  endtask

  initial begin
    logic [DW-1:0] a, b, c, d, h, p0, p1;
    logic [DW-1:0] ev[$];
    int            kind, len;

    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_frame_dut%0d", k), frame_cnt[k], 32'd0);
      chk($sformatf("reset_err_dut%0d", k), err_cnt[k], 16'd0);
      chk($sformatf("reset_busy_dut%0d", k), busy[k], 1'b0);
    end

    // Single len=3 frame, downstream always ready.
    a = rnd_word(); b = rnd_word(); c = rnd_word();
    clear_log(0);
    up_q[0].push_back(mk_hdr(MAGIC, 32'd3));
    up_q[0].push_back(a); up_q[0].push_back(b); up_q[0].push_back(c);
    wait_idle(0, 200);
    ev = '{a, b, c};
    check_log(0, "s1", ev);
    if (out_cyc[0].size() == 3) chk("s1_back_to_back", out_cyc[0][2] - out_cyc[0][0], 2);
    chk("s1_frame_cnt", frame_cnt[0], 32'd1);
    chk("s1_busy", busy[0], 1'b0);

    // Same frame with a 4-cycle downstream stall after B.
    clear_log(0);
    wr_seen[0]  = 0;
    stall_at[0] = 2;
    up_q[0].push_back(mk_hdr(MAGIC, 32'd3));
    up_q[0].push_back(a); up_q[0].push_back(b); up_q[0].push_back(c);
    wait_idle(0, 200);
    stall_at[0] = 0;
    check_log(0, "s2", ev);
    if (out_cyc[0].size() == 3) chk("s2_stall_gap", out_cyc[0][2] - out_cyc[0][1], 5);
    chk("s2_frame_cnt", frame_cnt[0], 32'd2);

    // Bad magic then a len=1 frame.
    d = rnd_word();
    clear_log(0);
    up_q[0].push_back(mk_hdr(32'hDEAD_BEEF, 32'd1));
    up_q[0].push_back(mk_hdr(MAGIC, 32'd1));
    up_q[0].push_back(d);
    wait_idle(0, 200);
    ev = '{d};
    check_log(0, "s3", ev);
    chk("s3_err_cnt", err_cnt[0], 16'd1);
    chk("s3_frame_cnt", frame_cnt[0], 32'd3);

    // Empty frame and an over-long length.
    clear_log(0);
    up_q[0].push_back(mk_hdr(MAGIC, 32'd0));
    up_q[0].push_back(mk_hdr(MAGIC, MAXB + 1));
    wait_idle(0, 200);
    ev.delete();
    check_log(0, "s4", ev);
    chk("s4_frame_cnt", frame_cnt[0], 32'd4);
    chk("s4_err_cnt", err_cnt[0], 16'd2);

    // Header forwarding instance.
    h = mk_hdr(MAGIC, 32'd2); p0 = rnd_word(); p1 = rnd_word();
    clear_log(1);
    up_q[1].push_back(h); up_q[1].push_back(p0); up_q[1].push_back(p1);
    wait_idle(1, 200);
    ev = '{h, p0, p1};
    check_log(1, "s5", ev);
    chk("s5_frame_cnt", frame_cnt[1], 32'd1);

    // Reset after the first of four payload beats; leftovers must be rejected as junk.
    clear_log(0);
    up_q[0].push_back(mk_hdr(MAGIC, 32'd4));
    for (int i = 0; i < 4; i++) up_q[0].push_back(junk_word());
    for (int n = 0; n < 200 && out_log[0].size() < 1; n++) @(posedge ap_clk);
    chk("s6_beats_before_rst", out_log[0].size(), 1);
    #1 ap_rst = 1'b1;
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    chk("s6_frame_after_rst", frame_cnt[0], 32'd0);
    chk("s6_err_after_rst", err_cnt[0], 16'd0);
    clear_log(0);
    d = rnd_word();
    up_q[0].push_back(mk_hdr(MAGIC, 32'd1));
    up_q[0].push_back(d);
    wait_idle(0, 200);
    ev = '{d};
    check_log(0, "s6", ev);
    chk("s6_err_cnt", err_cnt[0], 16'd3);
    chk("s6_frame_cnt", frame_cnt[0], 32'd1);

    // Randomised traffic with random upstream/downstream gaps on both instances.
    rand_mode = 1'b1;
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 2; k++) begin
        kind = $urandom_range(0, 9);
        if (kind < 7) begin
          len = $urandom_range(1, 6);
          up_q[k].push_back(mk_hdr(MAGIC, len));
          for (int i = 0; i < len; i++) up_q[k].push_back(rnd_word());
        end else if (kind == 7) begin
          up_q[k].push_back(mk_hdr(MAGIC, 32'd0));
        end else if (kind == 8) begin
          up_q[k].push_back(mk_hdr($urandom | 32'h1, $urandom_range(1, 6)) ^ {64'd0, MAGIC, 32'd0});
        end else begin
          up_q[k].push_back(mk_hdr(MAGIC, MAXB + 1 + $urandom_range(0, 1000)));
        end
      end
    end
    wait_idle(0, 5000);
    wait_idle(1, 5000);
    rand_mode = 1'b0;
    repeat (4) @(posedge ap_clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rand_drained_dut%0d", k), exp_q[k].size(), 0);
      chk($sformatf("rand_busy_dut%0d", k), busy[k], 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
